hb_tx_scheduler: RTL and testbench
==================================

HB_TX_SCHEDULER -- requirements
Module: hb_tx_scheduler

Interface
REQ-001 SHALL have parameter BURST_LEN, 16, cycles o_tx_ena_n is held low per burst (>=1).
REQ-002 SHALL have parameter GAP_LEN, 8, idle cycles between bursts (>=1).
REQ-003 SHALL have parameter NUM_BURSTS, 4, bursts per session (1..255).
REQ-004 SHALL have parameter WDOG_CYCLES, 1024, cycles allowed for a hit-count report (used only with HB_SCHED_WDOG_EN).
REQ-005 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_start  input  1  one-cycle session start request.
REQ-008 SHALL have port i_abort  input  1  one-cycle session abort request.
REQ-009 SHALL have port i_hit_count  input  28  hit count reported by the tx/rx datapath.
REQ-010 SHALL have port i_hit_count_valid  input  1  qualifies i_hit_count for one cycle.
REQ-011 SHALL have port o_tx_ena_n  output  1  active-low transmit enable driven to the datapath.
REQ-012 SHALL have port o_busy  output  1  high while a session is in progress.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse at session end (normal or aborted).
REQ-014 SHALL have port o_burst_idx  output  8  index of the current burst, 0-based.
REQ-015 SHALL have port o_total_hits  output  32  session hit total, saturating.
REQ-016 SHALL have port o_timeout  output  1  sticky watchdog flag for the session.

Function
REQ-017 SHALL implement states IDLE, TX, WAIT, GAP, DONE.
REQ-018 IDLE: i_start=1 -> TX next cycle; clears o_total_hits, o_burst_idx, o_timeout; o_busy=1 from that cycle.
REQ-019 TX: o_tx_ena_n=0 for exactly BURST_LEN cycles, then -> WAIT.
REQ-020 WAIT: o_tx_ena_n=1; on i_hit_count_valid=1, add zero-extended i_hit_count to o_total_hits, then -> GAP.
REQ-021 Addition SHALL saturate at 32'hFFFF_FFFF; the value never wraps.
REQ-022 GAP: o_tx_ena_n=1 for GAP_LEN cycles; then, if o_burst_idx==NUM_BURSTS-1 -> DONE, else o_burst_idx+1 and -> TX.
REQ-023 DONE: o_done=1 for one cycle, o_busy=0, -> IDLE; o_total_hits and o_timeout hold until the next i_start.
REQ-024 i_hit_count_valid SHALL be ignored outside WAIT; at most one report is accepted per burst.
REQ-025 i_start SHALL be ignored when not in IDLE.
REQ-026 i_abort in TX, WAIT or GAP SHALL force o_tx_ena_n=1 the next cycle and -> DONE; i_abort in IDLE or DONE SHALL be ignored.
REQ-027 i_abort and i_hit_count_valid in the same WAIT cycle: abort wins and the report is discarded.
REQ-028 o_tx_ena_n SHALL be registered and glitch-free; it is low only in TX.

Reset
REQ-029 i_rst=1 SHALL, at the next rising edge, set state=IDLE, o_tx_ena_n=1, o_busy=0, o_done=0, o_burst_idx=0, o_total_hits=0, o_timeout=0.
REQ-030 Reset mid-session SHALL abandon the session without an o_done pulse.
REQ-031 Reset SHALL take priority over i_start and i_abort.

Configuration
REQ-032 With macro HB_SCHED_WDOG_EN defined: WAIT counts cycles; if WDOG_CYCLES elapse without a report, set o_timeout=1, add 0, and -> GAP.
REQ-033 Without HB_SCHED_WDOG_EN: WAIT waits indefinitely; o_timeout is tied to 0; no watchdog counter is built.

Verification
REQ-034 Use BURST_LEN=8, GAP_LEN=4, NUM_BURSTS=3: i_start, reports 5, 7, 9 one cycle after each WAIT entry -> o_tx_ena_n low for 3 windows of 8 cycles, o_total_hits=21, one o_done pulse.
REQ-035 Report 28'hFFF_FFFF in every burst with NUM_BURSTS=32 -> o_total_hits saturates at 32'hFFFF_FFFF.
REQ-036 i_abort on the 3rd TX cycle of burst 1 -> o_tx_ena_n=1 next cycle, o_done pulse, o_total_hits=5, o_burst_idx=1.
REQ-037 i_hit_count_valid pulses during TX and GAP, plus a second pulse in WAIT -> all ignored except the first WAIT report.
REQ-038 With HB_SCHED_WDOG_EN and WDOG_CYCLES=20, no reports -> o_timeout=1 and session ends with total 0; without the macro -> session stays in WAIT, o_busy=1.
REQ-039 i_rst asserted during GAP of burst 1 -> all outputs at reset values next cycle, no o_done; a fresh i_start then runs a full session.

Source files
------------

// File: rtl/hb_tx_scheduler.sv
// Burst transmit scheduler: NUM_BURSTS windows of active-low tx enable, each followed by a
// hit-count report and an idle gap. Optional WAIT watchdog is built when HB_SCHED_WDOG_EN is defined.
module hb_tx_scheduler #(
   parameter int BURST_LEN   = 16,
   parameter int GAP_LEN     = 8,
   parameter int NUM_BURSTS  = 4,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic [27:0] i_hit_count,
   input  logic        i_hit_count_valid,
   output logic        o_tx_ena_n,
   output logic        o_busy,
   output logic        o_done,
   output logic [7:0]  o_burst_idx,
   output logic [31:0] o_total_hits,
   output logic        o_timeout
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_TX   = 3'd1,
      ST_WAIT = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam int TG_MAX = (BURST_LEN > GAP_LEN) ? BURST_LEN : GAP_LEN;
`ifdef HB_SCHED_WDOG_EN
   localparam int CNT_MAX = (WDOG_CYCLES > TG_MAX) ? WDOG_CYCLES : TG_MAX;
`else
   localparam int CNT_MAX = TG_MAX;
`endif
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
   localparam logic [7:0]       BURST_LAST = 8'(NUM_BURSTS - 1);
`ifdef HB_SCHED_WDOG_EN
   localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(WDOG_CYCLES - 1);
`endif

   if ((BURST_LEN < 1) || (GAP_LEN < 1) || (NUM_BURSTS < 1) || (NUM_BURSTS > 255) ||
       (WDOG_CYCLES < 1)) begin : g_param_check
      $error("hb_tx_scheduler: parameter out of range");
   end

   // Accumulator never wraps: any carry out pins the total at all-ones.
   function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [27:0] inc);
      logic [32:0] sum_s;
      sum_s = {1'b0, acc} + {5'd0, inc};
      if (sum_s[32]) begin
         sat_add = 32'hFFFF_FFFF;
      end else begin
         sat_add = sum_s[31:0];
      end
   endfunction

   state_t           state_r, state_nx_s;
   logic [CNT_W-1:0] cnt_r, cnt_nx_s;
   logic [7:0]       idx_r, idx_nx_s;
   logic [31:0]      total_r, total_nx_s;
   logic             tx_ena_n_r, busy_r, done_r;
`ifdef HB_SCHED_WDOG_EN
   logic             timeout_r, timeout_nx_s;
`endif

   // Next-state, phase counter, burst index and hit accumulation
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      idx_nx_s   = idx_r;
      total_nx_s = total_r;
`ifdef HB_SCHED_WDOG_EN
      timeout_nx_s = timeout_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (i_start) begin
               state_nx_s = ST_TX;
               cnt_nx_s   = CNT_ZERO;
               idx_nx_s   = 8'd0;
               total_nx_s = 32'd0;
`ifdef HB_SCHED_WDOG_EN
               timeout_nx_s = 1'b0;
`endif
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_TX: begin
            if (i_abort) begin
               state_nx_s = ST_DONE;
               cnt_nx_s   = CNT_ZERO;
            end else if (cnt_r == TX_LAST) begin
               state_nx_s = ST_WAIT;
               cnt_nx_s   = CNT_ZERO;
            end else begin
               cnt_nx_s = cnt_r + CNT_ONE;
            end
         end
         ST_WAIT: begin
            // abort outranks a report arriving in the same cycle
            if (i_abort) begin
               state_nx_s = ST_DONE;
               cnt_nx_s   = CNT_ZERO;
            end else if (i_hit_count_valid) begin
               total_nx_s = sat_add(total_r, i_hit_count);
               state_nx_s = ST_GAP;
               cnt_nx_s   = CNT_ZERO;
`ifdef HB_SCHED_WDOG_EN
            end else if (cnt_r == WDOG_LAST) begin
               timeout_nx_s = 1'b1;
               state_nx_s   = ST_GAP;
               cnt_nx_s     = CNT_ZERO;
            end else begin
               cnt_nx_s = cnt_r + CNT_ONE;
            end
`else
            end else begin
               state_nx_s = ST_WAIT;
            end
`endif
         end
         ST_GAP: begin
            if (i_abort) begin
               state_nx_s = ST_DONE;
               cnt_nx_s   = CNT_ZERO;
            end else if (cnt_r == GAP_LAST) begin
               cnt_nx_s = CNT_ZERO;
               if (idx_r == BURST_LAST) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_TX;
                  idx_nx_s   = idx_r + 8'd1;
               end
            end else begin
               cnt_nx_s = cnt_r + CNT_ONE;
            end
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = CNT_ZERO;
         end
      endcase
   end

   // State registers; outputs are decoded from the next state so they change with it
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= CNT_ZERO;
         idx_r      <= 8'd0;
         total_r    <= 32'd0;
         tx_ena_n_r <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
`ifdef HB_SCHED_WDOG_EN
         timeout_r  <= 1'b0;
`endif
      end else begin
         state_r    <= state_nx_s;
         cnt_r      <= cnt_nx_s;
         idx_r      <= idx_nx_s;
         total_r    <= total_nx_s;
         tx_ena_n_r <= (state_nx_s != ST_TX);
         busy_r     <= (state_nx_s == ST_TX) || (state_nx_s == ST_WAIT) || (state_nx_s == ST_GAP);
         done_r     <= (state_nx_s == ST_DONE);
`ifdef HB_SCHED_WDOG_EN
         timeout_r  <= timeout_nx_s;
`endif
      end
   end

   assign o_tx_ena_n   = tx_ena_n_r;
   assign o_busy       = busy_r;
   assign o_done       = done_r;
   assign o_burst_idx  = idx_r;
   assign o_total_hits = total_r;
`ifdef HB_SCHED_WDOG_EN
   assign o_timeout    = timeout_r;
`else
   assign o_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_hb_tx_scheduler.sv
// Self-checking bench for hb_tx_scheduler: randomized sessions checked cycle by cycle against a
// schedule model built from burst/report/gap arithmetic. Honours HB_SCHED_WDOG_EN.
module tb_hb_tx_scheduler;

   localparam int B = 8, G = 4, NB = 3, WD = 20;
   localparam int SB = 2, SG = 1, SNB = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start_m, start_s, abort, hv;
   logic [27:0] hc;
   logic        m_tx, m_busy, m_done, m_to, s_tx, s_busy, s_done, s_to;
   logic [7:0]  m_idx, s_idx;
   logic [31:0] m_tot, s_tot;

   hb_tx_scheduler #(.BURST_LEN(B), .GAP_LEN(G), .NUM_BURSTS(NB), .WDOG_CYCLES(WD)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start_m), .i_abort(abort), .i_hit_count(hc),
      .i_hit_count_valid(hv), .o_tx_ena_n(m_tx), .o_busy(m_busy), .o_done(m_done),
      .o_burst_idx(m_idx), .o_total_hits(m_tot), .o_timeout(m_to));

   hb_tx_scheduler #(.BURST_LEN(SB), .GAP_LEN(SG), .NUM_BURSTS(SNB), .WDOG_CYCLES(WD)) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_start(start_s), .i_abort(abort), .i_hit_count(hc),
      .i_hit_count_valid(hv), .o_tx_ena_n(s_tx), .o_busy(s_busy), .o_done(s_done),
      .o_burst_idx(s_idx), .o_total_hits(s_tot), .o_timeout(s_to));

   int          checks = 0, failures = 0;
   bit          use_sat = 1'b0;
   int          dly [64];
   logic [27:0] hits[64];
   bit          send[64];
   int          t_tx[64], t_rep[64];
   int          done_seen;

   // Schedule model: burst k transmits from t_tx[k] for b cycles, reports at t_rep[k], then g gap cycles.
   task automatic run_session(input string name, input int b, input int g, input int nb,
                              input int abort_k, input int abort_off, input int rst_k,
                              input int rst_off, input bit noise, input bit wd);
      int t, t_done, t_end, a_at, r_at, last, m;
      longint acc;
      logic e_tx, e_busy, e_done, e_to, o_tx, o_busy, o_done, o_to;
      logic [7:0] e_idx, o_idx;
      logic [31:0] e_tot, o_tot;
      t = 1;
      for (int k = 0; k < nb; k++) begin
         t_tx[k] = t;
         t_rep[k] = t + b + dly[k];
         t = t_rep[k] + 1 + g;
      end
      t_done = t;
      a_at = -1;
      if (abort_k == -2) a_at = int'($urandom_range(t_done - 1, 1));
      else if (abort_k >= 0) a_at = t_tx[abort_k] + abort_off;
      r_at = (rst_k >= 0) ? t_tx[rst_k] + rst_off : -1;
      t_end = (a_at >= 0) ? a_at + 1 : t_done;
      last = (r_at >= 0) ? r_at + 3 : t_end + 3;
      done_seen = 0;
      for (int n = 0; n <= last; n++) begin
         @(negedge clk);
         o_tx = use_sat ? s_tx : m_tx;   o_busy = use_sat ? s_busy : m_busy;
         o_done = use_sat ? s_done : m_done; o_idx = use_sat ? s_idx : m_idx;
         o_tot = use_sat ? s_tot : m_tot; o_to = use_sat ? s_to : m_to;
         if (o_done === 1'b1) done_seen++;
         if (r_at >= 0 && n > r_at) begin
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_idx = 8'd0; e_tot = 32'd0; e_to = 1'b0;
         end else begin
            e_busy = (n >= 1) && (n < t_end);
            e_done = (n == t_end);
            e_tx = 1'b1;
            for (int k = 0; k < nb; k++)
               if (n >= 1 && n < t_end && n >= t_tx[k] && n < t_tx[k] + b) e_tx = 1'b0;
            m = (n < t_end) ? n : t_end - 1;
            e_idx = 8'd0;
            for (int k = 0; k < nb; k++) if (t_tx[k] <= m) e_idx = 8'(k);
            acc = 0;
            for (int k = 0; k < nb; k++)
               if (send[k] && t_rep[k] < n && (a_at < 0 || t_rep[k] < a_at)) acc += longint'(hits[k]);
            if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
            e_tot = acc[31:0];
            e_to = wd && (n > t_rep[0]);
         end
         checks += 3;
         if (o_tx !== e_tx) begin failures++; $display("FAIL %s tx_ena_n n=%0d got %b want %b", name, n, o_tx, e_tx); end
         if (o_busy !== e_busy) begin failures++; $display("FAIL %s busy n=%0d got %b want %b", name, n, o_busy, e_busy); end
         if (o_done !== e_done) begin failures++; $display("FAIL %s done n=%0d got %b want %b", name, n, o_done, e_done); end
         if (n > 0) begin
            checks += 3;
            if (o_idx !== e_idx) begin failures++; $display("FAIL %s burst_idx n=%0d got %0d want %0d", name, n, o_idx, e_idx); end
            if (o_tot !== e_tot) begin failures++; $display("FAIL %s total n=%0d got %h want %h", name, n, o_tot, e_tot); end
            if (o_to !== e_to) begin failures++; $display("FAIL %s timeout n=%0d got %b want %b", name, n, o_to, e_to); end
         end
         // inputs for cycle n, sampled at the next rising edge
         rst = (n == r_at);
         if (use_sat) start_s = (n == 0);
         else start_m = (n == 0) || (noise && n == 3 && n < t_end);
         abort = (n == a_at) || (noise && (n == t_end || n == t_end + 1));
         hv = 1'b0;
         hc = 28'd0;
         for (int k = 0; k < nb; k++) begin
            if (noise && n < t_end && (n == t_tx[k] + 2 || n == t_rep[k] + 1 || n == t_rep[k] + g)) begin
               hv = 1'b1; hc = 28'h0AB_CDEF;
            end
            if (send[k] && n == t_rep[k] && (a_at < 0 || n <= a_at) && (r_at < 0 || n < r_at)) begin
               hv = 1'b1; hc = hits[k];
            end
         end
         if (noise && n == t_end + 1) begin hv = 1'b1; hc = 28'h0AB_CDEF; end
      end
      rst = 1'b0; start_m = 1'b0; start_s = 1'b0; abort = 1'b0; hv = 1'b0; hc = 28'd0;
   endtask

   task automatic plan_fixed(input int d, input logic [27:0] h0, input logic [27:0] h1, input logic [27:0] h2);
      for (int k = 0; k < 64; k++) begin dly[k] = d; hits[k] = 28'd0; send[k] = 1'b1; end
      hits[0] = h0; hits[1] = h1; hits[2] = h2;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_m = 1'b1; start_s = 1'b1; abort = 1'b1; hv = 1'b1; hc = 28'h123_4567;
      @(negedge clk);
      checks += 7;
      if (m_tx !== 1'b1) begin failures++; $display("FAIL reset tx_ena_n got %b want 1", m_tx); end
      if (m_busy !== 1'b0) begin failures++; $display("FAIL reset busy got %b want 0", m_busy); end
      if (m_done !== 1'b0) begin failures++; $display("FAIL reset done got %b want 0", m_done); end
      if (m_idx !== 8'd0) begin failures++; $display("FAIL reset burst_idx got %0d want 0", m_idx); end
      if (m_tot !== 32'd0) begin failures++; $display("FAIL reset total got %h want 0", m_tot); end
      if (m_to !== 1'b0) begin failures++; $display("FAIL reset timeout got %b want 0", m_to); end
      if (s_busy !== 1'b0) begin failures++; $display("FAIL reset sat_busy got %b want 0", s_busy); end
      rst = 1'b0; start_m = 1'b0; start_s = 1'b0; abort = 1'b0; hv = 1'b0; hc = 28'd0;
      repeat (2) @(negedge clk);
      checks += 2;
      if (m_busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy got %b want 0", m_busy); end
      if (m_tx !== 1'b1) begin failures++; $display("FAIL reset_idle tx_ena_n got %b want 1", m_tx); end
   endtask

   task automatic test_basic();
      plan_fixed(1, 28'd5, 28'd7, 28'd9);
      run_session("basic", B, G, NB, -1, 0, -1, 0, 1'b0, 1'b0);
      checks += 3;
      if (m_tot !== 32'd21) begin failures++; $display("FAIL basic_total got %0d want 21", m_tot); end
      if (done_seen != 1) begin failures++; $display("FAIL basic_done_pulses got %0d want 1", done_seen); end
      if (m_idx !== 8'd2) begin failures++; $display("FAIL basic_idx got %0d want 2", m_idx); end
   endtask

   task automatic test_ignored_inputs();
      plan_fixed(0, 28'd3, 28'd4, 28'd6);
      dly[1] = 2;
      run_session("ignored", B, G, NB, -1, 0, -1, 0, 1'b1, 1'b0);
      checks += 2;
      if (m_tot !== 32'd13) begin failures++; $display("FAIL ignored_total got %0d want 13", m_tot); end
      if (done_seen != 1) begin failures++; $display("FAIL ignored_done_pulses got %0d want 1", done_seen); end
   endtask

   task automatic test_abort();
      plan_fixed(1, 28'd5, 28'd7, 28'd9);
      run_session("abort_tx", B, G, NB, 1, 2, -1, 0, 1'b0, 1'b0);
      checks += 3;
      if (m_tot !== 32'd5) begin failures++; $display("FAIL abort_total got %0d want 5", m_tot); end
      if (m_idx !== 8'd1) begin failures++; $display("FAIL abort_idx got %0d want 1", m_idx); end
      if (done_seen != 1) begin failures++; $display("FAIL abort_done_pulses got %0d want 1", done_seen); end
      plan_fixed(1, 28'd5, 28'd7, 28'd9);
      run_session("abort_vs_report", B, G, NB, 1, B + 1, -1, 0, 1'b0, 1'b0);
      checks += 1;
      if (m_tot !== 32'd5) begin failures++; $display("FAIL abort_report_total got %0d want 5", m_tot); end
   endtask

   task automatic test_reset_mid();
      plan_fixed(1, 28'd5, 28'd7, 28'd9);
      run_session("reset_gap", B, G, NB, -1, 0, 1, B + 3, 1'b0, 1'b0);
      checks += 2;
      if (done_seen != 0) begin failures++; $display("FAIL reset_gap_done_pulses got %0d want 0", done_seen); end
      if (m_tot !== 32'd0) begin failures++; $display("FAIL reset_gap_total got %0d want 0", m_tot); end
      plan_fixed(1, 28'd5, 28'd7, 28'd9);
      run_session("after_reset", B, G, NB, -1, 0, -1, 0, 1'b0, 1'b0);
      checks += 2;
      if (m_tot !== 32'd21) begin failures++; $display("FAIL after_reset_total got %0d want 21", m_tot); end
      if (done_seen != 1) begin failures++; $display("FAIL after_reset_done_pulses got %0d want 1", done_seen); end
   endtask

   task automatic test_saturation();
      plan_fixed(0, 28'hFFF_FFFF, 28'hFFF_FFFF, 28'hFFF_FFFF);
      for (int k = 0; k < SNB; k++) hits[k] = 28'hFFF_FFFF;
      use_sat = 1'b1;
      run_session("saturate", SB, SG, SNB, -1, 0, -1, 0, 1'b0, 1'b0);
      use_sat = 1'b0;
      checks += 3;
      if (s_tot !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_total got %h want ffffffff", s_tot); end
      if (s_idx !== 8'd31) begin failures++; $display("FAIL sat_idx got %0d want 31", s_idx); end
      if (done_seen != 1) begin failures++; $display("FAIL sat_done_pulses got %0d want 1", done_seen); end
   endtask

   task automatic test_wdog();
`ifdef HB_SCHED_WDOG_EN
      plan_fixed(WD - 1, 28'd0, 28'd0, 28'd0);
      for (int k = 0; k < 64; k++) send[k] = 1'b0;
      run_session("wdog", B, G, NB, -1, 0, -1, 0, 1'b0, 1'b1);
      checks += 3;
      if (m_to !== 1'b1) begin failures++; $display("FAIL wdog_timeout got %b want 1", m_to); end
      if (m_tot !== 32'd0) begin failures++; $display("FAIL wdog_total got %0d want 0", m_tot); end
      if (done_seen != 1) begin failures++; $display("FAIL wdog_done_pulses got %0d want 1", done_seen); end
`else
      @(negedge clk); start_m = 1'b1;
      @(negedge clk); start_m = 1'b0;
      repeat (B + 40) @(negedge clk);
      checks += 4;
      if (m_busy !== 1'b1) begin failures++; $display("FAIL nowdog_busy got %b want 1", m_busy); end
      if (m_tx !== 1'b1) begin failures++; $display("FAIL nowdog_tx_ena_n got %b want 1", m_tx); end
      if (m_idx !== 8'd0) begin failures++; $display("FAIL nowdog_idx got %0d want 0", m_idx); end
      if (m_to !== 1'b0) begin failures++; $display("FAIL nowdog_timeout got %b want 0", m_to); end
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      checks += 2;
      if (m_done !== 1'b1) begin failures++; $display("FAIL nowdog_abort_done got %b want 1", m_done); end
      if (m_busy !== 1'b0) begin failures++; $display("FAIL nowdog_abort_busy got %b want 0", m_busy); end
      repeat (2) @(negedge clk);
`endif
   endtask

   task automatic test_random();
      for (int s = 0; s < 6; s++) begin
         for (int k = 0; k < 64; k++) begin
            dly[k] = int'($urandom_range(5, 0));
            hits[k] = 28'($urandom);
            send[k] = 1'b1;
         end
         run_session("random", B, G, NB, ($urandom_range(1, 0) == 1) ? -2 : -1, 0, -1, 0,
                     1'($urandom_range(1, 0)), 1'b0);
         checks += 1;
         if (done_seen != 1) begin failures++; $display("FAIL random_done_pulses s=%0d got %0d want 1", s, done_seen); end
      end
   endtask

   initial begin
      rst = 1'b0; start_m = 1'b0; start_s = 1'b0; abort = 1'b0; hv = 1'b0; hc = 28'd0;
      test_reset();
      test_basic();
      test_ignored_inputs();
      test_abort();
      test_reset_mid();
      test_saturation();
      test_wdog();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
